// File: rtl/counter_ctrl_if.sv
// Configuration/control handshake and counter status bundle for counter_ctrl.
interface counter_ctrl_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TCW   = 8
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [WIDTH-1:0] cfg_period;
    logic             cfg_periodic;
    logic             start;
    logic             stop;
    logic             busy;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic [TCW-1:0]   tick_total;

    // Controller side: issues configuration and start/stop, observes status.
    modport master (
        output cfg_valid, cfg_period, cfg_periodic, start, stop,
        input  cfg_ready, busy, tick, count, tick_total
    );

    // Counter side: consumes configuration and start/stop, produces status.
    modport slave (
        input  cfg_valid, cfg_period, cfg_periodic, start, stop,
        output cfg_ready, busy, tick, count, tick_total
    );
endinterface

// File: rtl/counter_ctrl.sv
// Configurable one-shot / periodic down-counter with terminal-count tick
// and a saturating tick total since the last accepted configuration.
module counter_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned TCW   = 8
) (
    input  logic           clk,
    input  logic           rst,
    counter_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_e;

    state_e           state_q,    state_d;
    logic [WIDTH-1:0] count_q,    count_d;
    logic [TCW-1:0]   total_q,    total_d;
    logic [WIDTH-1:0] period_q,   period_d;
    logic             periodic_q, periodic_d;

    logic             tick_c;
    logic             cfg_ready_c;
    logic [WIDTH-1:0] reload_c;
    logic [WIDTH-1:0] cfg_reload_c;

    // Status decode; period 0 wraps to an all-ones reload, i.e. 2^WIDTH cycles.
    assign tick_c       = (state_q == RUN) && (count_q == '0);
    assign cfg_ready_c  = (state_q != RUN);
    assign reload_c     = period_q - WIDTH'(1);
    assign cfg_reload_c = bus.cfg_period - WIDTH'(1);

    assign bus.tick       = tick_c;
    assign bus.cfg_ready  = cfg_ready_c;
    assign bus.busy       = (state_q == RUN);
    assign bus.count      = count_q;
    assign bus.tick_total = total_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            total_q    <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            total_q    <= total_d;
            period_q   <= period_d;
            periodic_q <= periodic_d;
        end
    end

    // Next-state and datapath update; stop outranks start, cfg outranks start.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        total_d    = total_q;
        period_d   = period_q;
        periodic_d = periodic_q;

        unique case (state_q)
            IDLE: begin
                if (bus.cfg_valid) begin
                    period_d   = bus.cfg_period;
                    periodic_d = bus.cfg_periodic;
                    count_d    = cfg_reload_c;
                    total_d    = '0;
                    state_d    = ARMED;
                end
            end
            ARMED: begin
                if (bus.cfg_valid) begin
                    period_d   = bus.cfg_period;
                    periodic_d = bus.cfg_periodic;
                    count_d    = cfg_reload_c;
                    total_d    = '0;
                end else if (bus.stop) begin
                    count_d = reload_c;
                end else if (bus.start) begin
                    count_d = reload_c;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (tick_c && (total_q != {TCW{1'b1}})) begin
                    total_d = total_q + TCW'(1);
                end
                if (bus.stop) begin
                    count_d = reload_c;
                    state_d = ARMED;
                end else if (tick_c) begin
                    count_d = reload_c;
                    if (!periodic_q) begin
                        state_d = ARMED;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

endmodule

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the counter and period width in bits.
REQ-002 SHALL have parameter TCW, default 8, giving the tick-total counter width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cfg_valid  input  1  configuration request.
REQ-006 SHALL have port cfg_ready  output  1  configuration can be accepted this cycle.
REQ-007 SHALL have port cfg_period  input  WIDTH  period P; value 0 means 2^WIDTH.
REQ-008 SHALL have port cfg_periodic  input  1  mode: 1 periodic, 0 one-shot.
REQ-009 SHALL have port start  input  1  begin counting.
REQ-010 SHALL have port stop  input  1  abort counting.
REQ-011 SHALL have port busy  output  1  high in RUN state.
REQ-012 SHALL have port tick  output  1  terminal-count pulse.
REQ-013 SHALL have port count  output  WIDTH  current down-counter value.
REQ-014 SHALL have port tick_total  output  TCW  saturating count of ticks since the last accepted configuration.

Function
REQ-015 SHALL implement FSM states IDLE (unconfigured), ARMED (configured, stopped) and RUN (counting).
REQ-016 SHALL drive cfg_ready = 1 in IDLE and ARMED and 0 in RUN; cfg_valid in RUN is ignored, not queued.
REQ-017 SHALL, on cfg_valid && cfg_ready, latch period and mode, set count = P-1 (2^WIDTH-1 for P=0), clear tick_total and enter ARMED next cycle.
REQ-018 SHALL, on start in ARMED with no cfg accept and no stop, enter RUN next cycle with count = P-1.
REQ-019 SHALL ignore start in IDLE and in RUN.
REQ-020 SHALL decrement count by 1 per cycle in RUN while count != 0.
REQ-021 SHALL drive tick combinationally as (state == RUN && count == 0); tick lasts one cycle per period.
REQ-022 SHALL, with start in cycle N, assert tick in cycle N+P (N+2^WIDTH for P=0).
REQ-023 SHALL, at tick in periodic mode, reload count = P-1 and stay in RUN, giving ticks at N+P, N+2P, and so on.
REQ-024 SHALL, at tick in one-shot mode, enter ARMED next cycle with count = P-1.
REQ-025 SHALL, on stop in RUN, enter ARMED next cycle with count = P-1; stop in IDLE or ARMED has no effect.
REQ-026 SHALL, when stop and tick occur in the same cycle, still assert tick and increment tick_total, with stop deciding the next state (ARMED).
REQ-027 SHALL, when start and stop occur in the same ARMED cycle, let stop win and stay in ARMED.
REQ-028 SHALL, when cfg accept and start occur in the same ARMED cycle, accept the configuration and ignore start.
REQ-029 SHALL increment tick_total on each tick and saturate it at 2^TCW-1 without wrapping.
REQ-030 SHALL drive busy = (state == RUN).
REQ-031 SHALL accept P=1 in periodic mode, giving tick continuously high in every RUN cycle.

Reset
REQ-032 SHALL, on rst high at a clock edge, set state IDLE, count 0, tick_total 0, stored period 0 and stored mode one-shot.
REQ-033 SHALL, after reset, drive tick = 0, busy = 0 and cfg_ready = 1.
REQ-034 SHALL give rst priority over every other input in every state, including mid-RUN and during a tick cycle.
REQ-035 SHALL ignore start while in IDLE after reset until a configuration has been accepted.

Verification
REQ-036 Bench SHALL cover: rst for 2 cycles -> IDLE, count=0, tick=0, busy=0, cfg_ready=1, tick_total=0.
REQ-037 Bench SHALL cover: cfg P=3 one-shot, start at cycle 10 -> count 2,1,0 in cycles 11-13, tick only at 13, ARMED with count=2 at 14, tick_total=1.
REQ-038 Bench SHALL cover: cfg P=2 periodic, start at cycle 20 -> ticks at 22, 24, 26, 28, tick_total=4 after cycle 28, busy held high.
REQ-039 Bench SHALL cover: cfg P=0 one-shot, start at cycle 5 -> single tick at cycle 21, count starting at 15.
REQ-040 Bench SHALL cover: P=4 periodic, stop asserted on the tick cycle -> tick high in that cycle, ARMED next, no further ticks, tick_total=1.
REQ-041 Bench SHALL cover: cfg_valid with P=7 during RUN -> cfg_ready=0 and the old period is kept; rst mid-RUN -> IDLE next cycle and start ignored until reconfigured.
